// File: rtl/wb_result_select_if.sv
// Writeback-select stage interface: instruction result inputs, data-memory return and
// register-file write port. The stage drives in_ready and the writeback/err signals.
interface wb_result_select_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NSRC*XLEN-1:0] src_bus;
    logic [SELW-1:0]      sel;
    logic [4:0]           rd_in;
    logic [2:0]           funct3;
    logic [1:0]           addr_lo;
    logic [XLEN-1:0]      mem_rdata;
    logic                 mem_valid;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 err;

    modport master (
        output in_valid, src_bus, sel, rd_in, funct3, addr_lo, mem_rdata, mem_valid,
        input  in_ready, wb_en, wb_rd, wb_data, err
    );

    modport slave (
        input  in_valid, src_bus, sel, rd_in, funct3, addr_lo, mem_rdata, mem_valid,
        output in_ready, wb_en, wb_rd, wb_data, err
    );
endinterface

// File: rtl/wb_result_select.sv
// Writeback-select stage: picks one of NSRC results (or formatted load data), registers it
// onto the register-file write port, and stalls in WAIT_MEM until a load's data returns.
//
//   state    | meaning
//   IDLE     | ready; accepts one instruction per cycle
//   WAIT_MEM | load accepted without data; waiting for mem_valid or timeout
module wb_result_select #(
    parameter int XLEN    = 32,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int MEM_IDX = 1,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    wb_result_select_if.slave bus
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      ld_rd_q;
    logic [2:0]      ld_f3_q;
    logic [1:0]      ld_lo_q;
    logic            wb_en_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            err_q;

    logic            accept;
    logic            sel_is_mem;
    logic            sel_legal;
    logic [XLEN-1:0] src_word;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_lo;
    logic [XLEN-1:0] load_word;

    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = raw[{lo, 3'b000} +: 8];
        h = raw[{lo[1], 4'b0000} +: 16];
        w = raw[31:0];
        case (f3)
            3'b000:  fmt_load = XLEN'(signed'(b));
            3'b001:  fmt_load = XLEN'(signed'(h));
            3'b010:  fmt_load = XLEN'(signed'(w));
            3'b100:  fmt_load = XLEN'(b);
            3'b101:  fmt_load = XLEN'(h);
            3'b110:  fmt_load = XLEN'(w);
            default: fmt_load = raw;
        endcase
    endfunction

    assign bus.in_ready = (state_q == IDLE) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign sel_is_mem   = int'(bus.sel) == MEM_IDX;
    assign sel_legal    = int'(bus.sel) < NSRC;

    // In WAIT_MEM the captured load attributes apply; the live inputs belong to the next instruction.
    assign ld_f3     = (state_q == WAIT_MEM) ? ld_f3_q : bus.funct3;
    assign ld_lo     = (state_q == WAIT_MEM) ? ld_lo_q : bus.addr_lo;
    assign load_word = fmt_load(bus.mem_rdata, ld_f3, ld_lo);

    always_comb begin
        src_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(bus.sel) == i) src_word = bus.src_bus[i*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_is_mem) begin
                            if (bus.mem_valid) begin
                                wb_data_q <= load_word;
                                wb_rd_q   <= bus.rd_in;
                                wb_en_q   <= bus.rd_in != 5'd0;
                            end else begin
                                ld_rd_q <= bus.rd_in;
                                ld_f3_q <= bus.funct3;
                                ld_lo_q <= bus.addr_lo;
                                cnt_q   <= '0;
                                state_q <= WAIT_MEM;
                            end
                        end else if (sel_legal) begin
                            wb_data_q <= src_word;
                            wb_rd_q   <= bus.rd_in;
                            wb_en_q   <= bus.rd_in != 5'd0;
                        end else begin
                            wb_data_q <= '0;
                            err_q     <= 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_valid) begin
                        wb_data_q <= load_word;
                        wb_rd_q   <= ld_rd_q;
                        wb_en_q   <= ld_rd_q != 5'd0;
                        state_q   <= IDLE;
                    end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wb_en   = wb_en_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_wb_result_select.sv
// Bench for wb_result_select (NSRC=3, MEM_IDX=1, TIMEOUT=4): a transaction-level model checked
// every cycle, plus hand-computed literal checks along the directed stimulus.
module tb_wb_result_select;
    localparam int XLEN = 32, NSRC = 3, SELW = 2, MEM_IDX = 1, TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   chk = 0;
    int   errs = 0;

    wb_result_select_if #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW)) bus ();

    wb_result_select #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .MEM_IDX(MEM_IDX),
                       .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] src [0:NSRC-1];
    assign bus.src_bus = {src[2], src[1], src[0]};

    function automatic logic [31:0] model_load(input logic [31:0] raw, input int f3, input int lo);
        int s;
        case (f3)
            0: begin s = int'((raw >> (lo * 8)) & 32'hFF);         if (s > 127)   s -= 256;   end
            1: begin s = int'((raw >> ((lo / 2) * 16)) & 32'hFFFF); if (s > 32767) s -= 65536; end
            4: s = int'((raw >> (lo * 8)) & 32'hFF);
            5: s = int'((raw >> ((lo / 2) * 16)) & 32'hFFFF);
            default: s = int'(raw);
        endcase
        return 32'(s);
    endfunction

    // Model: pending-load record plus count of cycles spent waiting.
    bit          m_busy = 0;
    int          m_waited = 0;
    int          m_rd = 0, m_f3 = 0, m_lo = 0;
    logic        e_en = 0, e_err = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_data = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic write_back(input int rd, input logic [31:0] d);
        e_data = d;
        e_rd   = 5'(rd);
        e_en   = (rd != 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            e_en = 0; e_err = 0; e_rd = 0; e_data = 0;
        end
        cmp("wb_en",    32'(bus.wb_en),    32'(e_en));
        cmp("err",      32'(bus.err),      32'(e_err));
        cmp("wb_rd",    32'(bus.wb_rd),    32'(e_rd));
        cmp("wb_data",  bus.wb_data,       e_data);
        cmp("in_ready", 32'(bus.in_ready), 32'(!m_busy && !reset));
        e_en = 0; e_err = 0;
        if (reset) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                if (int'(bus.sel) == MEM_IDX) begin
                    if (bus.mem_valid)
                        write_back(int'(bus.rd_in),
                                   model_load(bus.mem_rdata, int'(bus.funct3), int'(bus.addr_lo)));
                    else begin
                        m_busy = 1; m_waited = 0;
                        m_rd = int'(bus.rd_in); m_f3 = int'(bus.funct3); m_lo = int'(bus.addr_lo);
                    end
                end else if (int'(bus.sel) < NSRC) begin
                    write_back(int'(bus.rd_in), src[int'(bus.sel)]);
                end else begin
                    e_data = 0; e_err = 1;
                end
            end
        end else begin
            if (bus.mem_valid) begin
                write_back(m_rd, model_load(bus.mem_rdata, m_f3, m_lo));
                m_busy = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    e_err = 1; m_busy = 0;
                end
            end
        end
    end

    task automatic drive(input bit v, input int s, input int rd, input int f3, input int lo,
                         input bit mv, input logic [31:0] md);
        bus.in_valid  = v;
        bus.sel       = SELW'(s);
        bus.rd_in     = 5'(rd);
        bus.funct3    = 3'(f3);
        bus.addr_lo   = 2'(lo);
        bus.mem_valid = mv;
        bus.mem_rdata = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        src[0] = 32'h1234_5678;
        src[1] = 32'hAAAA_AAAA;
        src[2] = 32'hCAFE_F00D;
        bus.in_valid = 0; bus.sel = 0; bus.rd_in = 0; bus.funct3 = 0; bus.addr_lo = 0;
        bus.mem_valid = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset wb_en", 32'(bus.wb_en), 32'h0);
        cmp("reset wb_data", bus.wb_data, 32'h0);
        cmp("reset in_ready", 32'(bus.in_ready), 32'h0);
        reset = 0;
        idle(1);

        // ALU pass
        drive(1, 0, 5, 0, 0, 0, 32'h0);
        cmp("alu wb_en", 32'(bus.wb_en), 32'h1);
        cmp("alu wb_rd", 32'(bus.wb_rd), 32'd5);
        cmp("alu wb_data", bus.wb_data, 32'h1234_5678);
        idle(1);
        cmp("alu pulse", 32'(bus.wb_en), 32'h0);
        cmp("alu hold", bus.wb_data, 32'h1234_5678);

        // Same-cycle loads, signed then unsigned byte
        drive(1, 1, 7, 0, 2, 1, 32'h0080_0000);
        cmp("lb wb_data", bus.wb_data, 32'hFFFF_FF80);
        drive(1, 1, 7, 4, 2, 1, 32'h0080_0000);
        cmp("lbu wb_data", bus.wb_data, 32'h0000_0080);
        cmp("lbu wb_en", 32'(bus.wb_en), 32'h1);
        drive(1, 1, 8, 1, 3, 1, 32'h8001_7FFF);
        cmp("lh hi lane", bus.wb_data, 32'hFFFF_8001);
        idle(1);

        // Load wait: three stalled cycles, then LHU from upper half
        drive(1, 1, 9, 5, 2, 0, 32'h0);
        cmp("wait ready 1", 32'(bus.in_ready), 32'h0);
        drive(1, 0, 3, 0, 0, 0, 32'h0);
        cmp("wait ready 2", 32'(bus.in_ready), 32'h0);
        cmp("wait no wb", 32'(bus.wb_en), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        cmp("wait ready 3", 32'(bus.in_ready), 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cmp("wait wb_data", bus.wb_data, 32'h0000_DEAD);
        cmp("wait wb_en", 32'(bus.wb_en), 32'h1);
        cmp("wait wb_rd", 32'(bus.wb_rd), 32'd9);
        cmp("wait ready after", 32'(bus.in_ready), 32'h1);
        idle(1);

        // Stray mem_valid while idle is ignored
        drive(0, 0, 0, 0, 0, 1, 32'h5555_5555);
        cmp("stray mem", 32'(bus.wb_en), 32'h0);

        // Timeout after four waiting cycles
        drive(1, 1, 10, 2, 0, 0, 32'h0);
        idle(3);
        cmp("to before err", 32'(bus.err), 32'h0);
        cmp("to before ready", 32'(bus.in_ready), 32'h0);
        idle(1);
        cmp("to err", 32'(bus.err), 32'h1);
        cmp("to wb_en", 32'(bus.wb_en), 32'h0);
        cmp("to ready", 32'(bus.in_ready), 32'h1);
        idle(1);
        cmp("to err pulse", 32'(bus.err), 32'h0);

        // mem_valid in the expiry cycle wins
        drive(1, 1, 11, 2, 0, 0, 32'h0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1, 32'h1122_3344);
        cmp("late err", 32'(bus.err), 32'h0);
        cmp("late wb_en", 32'(bus.wb_en), 32'h1);
        cmp("late wb_data", bus.wb_data, 32'h1122_3344);
        idle(1);

        // rd=0, illegal sel, back-to-back
        drive(1, 2, 0, 0, 0, 0, 32'h0);
        cmp("rd0 wb_en", 32'(bus.wb_en), 32'h0);
        cmp("rd0 wb_data", bus.wb_data, 32'hCAFE_F00D);
        drive(1, 3, 4, 0, 0, 0, 32'h0);
        cmp("badsel err", 32'(bus.err), 32'h1);
        cmp("badsel wb_en", 32'(bus.wb_en), 32'h0);
        cmp("badsel wb_data", bus.wb_data, 32'h0);
        drive(1, 0, 1, 0, 0, 0, 32'h0);
        cmp("b2b 1", 32'(bus.wb_en), 32'h1);
        drive(1, 2, 2, 0, 0, 0, 32'h0);
        cmp("b2b 2", 32'(bus.wb_en), 32'h1);
        cmp("b2b 2 data", bus.wb_data, 32'hCAFE_F00D);
        drive(1, 0, 3, 0, 0, 0, 32'h0);
        cmp("b2b 3", 32'(bus.wb_en), 32'h1);
        cmp("b2b 3 rd", 32'(bus.wb_rd), 32'd3);

        // Reset in WAIT_MEM
        drive(1, 1, 12, 2, 0, 0, 32'h0);
        idle(1);
        reset = 1;
        #1;
        cmp("rst wb_data", bus.wb_data, 32'h0);
        cmp("rst wb_rd", 32'(bus.wb_rd), 32'h0);
        cmp("rst in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        drive(0, 0, 0, 0, 0, 1, 32'h7777_7777);
        cmp("rst no wb", 32'(bus.wb_en), 32'h0);
        cmp("rst no err", 32'(bus.err), 32'h0);
        cmp("rst ready", 32'(bus.in_ready), 32'h1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end
endmodule
